// File: rtl/xgemac_rx_pkg.sv
// Shared types for the XGE MAC receive drain.
// Holds the beat constants, FSM state encoding and the packed beat record.
package xgemac_rx_pkg;

    localparam int XGEMAC_TX_RX_DATA_WIDTH = 64;
    localparam int XGEMAC_TX_RX_MOD        = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [XGEMAC_TX_RX_DATA_WIDTH-1:0] data;
        logic                               sop;
        logic                               eop;
        logic [XGEMAC_TX_RX_MOD-1:0]        mod;
        logic                               err;
    } rx_beat_t;

endpackage

// File: rtl/xgemac_rx_sync_fifo.sv
// Synchronous FIFO of receive beats with occupancy count.
// Ports: clk, rst (async active-low), i_push/i_data in, i_pop in,
//        o_data (head), o_empty, o_count (0..DEPTH).
module xgemac_rx_sync_fifo
    import xgemac_rx_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  rx_beat_t      i_data,
    input  logic          i_pop,
    output rx_beat_t      o_data,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    rx_beat_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is only taken when the head leaves the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xgemac_rx_drain.sv
// Drains frames from the XGE MAC receive port into a valid/ready stream.
// Ports: clk, rst (async active-low); MAC side pkt_rx_avail/ren/val/data/
//        sop/eop/mod/err; stream m_valid/m_ready/m_data/m_sop/m_eop/m_mod/
//        m_err; status frame_cnt, err_cnt, proto_err_cnt.
module xgemac_rx_drain
    import xgemac_rx_pkg::*;
#(
    parameter int DATA_WIDTH = XGEMAC_TX_RX_DATA_WIDTH,
    parameter int MOD_WIDTH  = XGEMAC_TX_RX_MOD,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_rx_avail,
    output logic                  pkt_rx_ren,
    input  logic                  pkt_rx_val,
    input  logic [DATA_WIDTH-1:0] pkt_rx_data,
    input  logic                  pkt_rx_sop,
    input  logic                  pkt_rx_eop,
    input  logic [MOD_WIDTH-1:0]  pkt_rx_mod,
    input  logic                  pkt_rx_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [MOD_WIDTH-1:0]  m_mod,
    output logic                  m_err,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  proto_err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_state_e       r_state;
    rx_state_e       w_state_nxt;
    logic            r_ren_q;
    logic            r_in_frame;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [CNT_WIDTH-1:0] r_proto_cnt;
    logic [AW:0]     w_count;
    logic            w_empty;
    logic            w_credit_ok;
    logic            w_eop_in;
    logic            w_ren;
    logic            w_pop;
    logic [1:0]      w_proto_inc;
    rx_beat_t        w_in_beat;
    rx_beat_t        w_head;

    assign w_eop_in = pkt_rx_val && pkt_rx_eop;

    // The beat requested last cycle is still in flight, so it holds a slot.
    // A same-cycle pop is not credited back.
    assign w_credit_ok = ({1'b0, w_count} + {{(AW+1){1'b0}}, r_ren_q})
                         < (AW+2)'(FIFO_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (pkt_rx_avail) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_ren = w_credit_ok && !w_eop_in;
                if (w_eop_in) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_beat      = '0;
        w_in_beat.data = pkt_rx_data;
        w_in_beat.sop  = pkt_rx_sop;
        w_in_beat.eop  = pkt_rx_eop;
        w_in_beat.mod  = pkt_rx_mod;
        w_in_beat.err  = pkt_rx_err;
    end

    // Each framing violation on a beat adds one; several may coincide.
    assign w_proto_inc =
        {1'b0, pkt_rx_val && pkt_rx_sop && r_in_frame}
      + {1'b0, pkt_rx_val && !pkt_rx_sop && !r_in_frame}
      + {1'b0, pkt_rx_val && !r_ren_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ren_q     <= 1'b0;
            r_in_frame  <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_proto_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ren_q     <= w_ren;
            r_proto_cnt <= r_proto_cnt + CNT_WIDTH'(w_proto_inc);
            if (pkt_rx_val) begin
                if (pkt_rx_eop) r_in_frame <= 1'b0;
                else if (pkt_rx_sop) r_in_frame <= 1'b1;
            end
            if (w_eop_in) begin
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                if (pkt_rx_err) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    xgemac_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (pkt_rx_val),
        .i_data  (w_in_beat),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign pkt_rx_ren    = w_ren;
    assign m_valid       = !w_empty;
    assign w_pop         = m_valid && m_ready;
    assign m_data        = w_head.data;
    assign m_sop         = w_head.sop;
    assign m_eop         = w_head.eop;
    assign m_mod         = w_head.mod;
    assign m_err         = w_head.err;
    assign frame_cnt     = r_frame_cnt;
    assign err_cnt       = r_err_cnt;
    assign proto_err_cnt = r_proto_cnt;

endmodule

// File: tb/tb_xgemac_rx_drain.sv
// Directed bench for xgemac_rx_drain with a cycle-stepped MAC model.
// Ports of the DUT are all driven/observed from one stimulus process.
module tb_xgemac_rx_drain;
    import xgemac_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pkt_rx_avail = 1'b0;
    logic        pkt_rx_ren;
    logic        pkt_rx_val = 1'b0;
    logic [63:0] pkt_rx_data = '0;
    logic        pkt_rx_sop = 1'b0;
    logic        pkt_rx_eop = 1'b0;
    logic [2:0]  pkt_rx_mod = '0;
    logic        pkt_rx_err = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic [2:0]  m_mod;
    logic        m_err;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;
    logic [31:0] proto_err_cnt;

    always #5 clk = ~clk;

    xgemac_rx_drain dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_rx_avail  (pkt_rx_avail),
        .pkt_rx_ren    (pkt_rx_ren),
        .pkt_rx_val    (pkt_rx_val),
        .pkt_rx_data   (pkt_rx_data),
        .pkt_rx_sop    (pkt_rx_sop),
        .pkt_rx_eop    (pkt_rx_eop),
        .pkt_rx_mod    (pkt_rx_mod),
        .pkt_rx_err    (pkt_rx_err),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_sop         (m_sop),
        .m_eop         (m_eop),
        .m_mod         (m_mod),
        .m_err         (m_err),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .proto_err_cnt (proto_err_cnt)
    );

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       first_ren = -1;
    int       first_mv = -1;
    int       ren_cnt = 0;
    int       eop_ren = 0;
    int       p = 0;
    bit       found;
    bit       inj_pend = 1'b0;
    rx_beat_t inj;
    rx_beat_t mac_q[$];
    rx_beat_t exp_q[$];
    rx_beat_t out_q[$];

    function automatic rx_beat_t mk(input logic [63:0] d, input logic s,
                                    input logic e, input logic [2:0] m,
                                    input logic r);
        rx_beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        b.mod  = m;
        b.err  = r;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input rx_beat_t b);
        mac_q.push_back(b);
        exp_q.push_back(b);
        pkt_rx_avail = 1'b1;
    endtask

    task automatic frame(input int n, input logic [63:0] base,
                         input logic [2:0] m, input logic r);
        for (int i = 0; i < n; i++) begin
            push(mk(base + 64'(i), i == 0, i == n - 1,
                    (i == n - 1) ? m : 3'd0, (i == n - 1) ? r : 1'b0));
        end
    endtask

    task automatic drive(input rx_beat_t b);
        pkt_rx_val  = 1'b1;
        pkt_rx_data = b.data;
        pkt_rx_sop  = b.sop;
        pkt_rx_eop  = b.eop;
        pkt_rx_mod  = b.mod;
        pkt_rx_err  = b.err;
    endtask

    // One clock: observe settled outputs, cross the edge, then let the MAC
    // answer a read issued in the cycle just ended.
    task automatic step();
        logic ren_s;
        ren_s = pkt_rx_ren;
        if (ren_s) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (ren_s && pkt_rx_val && pkt_rx_eop) eop_ren++;
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready)
            out_q.push_back(mk(m_data, m_sop, m_eop, m_mod, m_err));
        @(posedge clk);
        #1;
        cyc++;
        if (ren_s && mac_q.size() != 0) begin
            drive(mac_q.pop_front());
        end else if (inj_pend && !ren_s) begin
            drive(inj);
            inj_pend = 1'b0;
        end else begin
            drive('0);
            pkt_rx_val = 1'b0;
        end
        pkt_rx_avail = (mac_q.size() != 0);
        #1;
    endtask

    task automatic run(input string tag, input int n, input int lim);
        for (int k = 0; k < lim && out_q.size() < n; k++) step();
        chk(tag, out_q.size(), n);
        step();
        step();
    endtask

    task automatic cmpq(input string tag);
        for (int i = 0; i < exp_q.size(); i++) chk(tag, out_q[i], exp_q[i]);
        chk({tag, "_n"}, out_q.size(), exp_q.size());
    endtask

    task automatic clr();
        out_q.delete();
        exp_q.delete();
        ren_cnt = 0;
        eop_ren = 0;
        first_ren = -1;
        first_mv = -1;
    endtask

    initial begin
        #2;
        step();
        step();
        chk("rst_ren", pkt_rx_ren, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_proto", proto_err_cnt, 0);
        rst = 1'b1;
        #1;
        step();
        step();

        // Single 8-beat frame, last mod 3.
        clr();
        p = cyc;
        frame(8, 64'h1111_0000_0000_0000, 3'd3, 1'b0);
        run("t1_tmo", 8, 60);
        chk("t1_ren_cnt", ren_cnt, 8);
        chk("t1_avail_lat", first_ren - p, 1);
        chk("t1_out_lat", first_mv - first_ren, 2);
        chk("t1_last", {out_q[7].eop, out_q[7].mod}, {1'b1, 3'd3});
        cmpq("t1_beat");
        chk("t1_frame", frame_cnt, 1);
        chk("t1_err", err_cnt, 0);

        // 20-beat frame with a 10-cycle stall.
        clr();
        frame(20, 64'h2222_0000_0000_0000, 3'd0, 1'b0);
        for (int i = 0; i < 100 && out_q.size() < 20; i++) begin
            m_ready = !(i >= 3 && i <= 12);
            #1;
            if (i == 8) chk("t2_ren_stall", pkt_rx_ren, 0);
            if (i == 12) begin
                chk("t2_ren_full", pkt_rx_ren, 0);
                chk("t2_hold_valid", m_valid, 1);
                chk("t2_hold_data", m_data, 64'h2222_0000_0000_0000);
            end
            step();
        end
        m_ready = 1'b1;
        run("t2_tmo", 20, 5);
        chk("t2_ren_cnt", ren_cnt, 20);
        cmpq("t2_beat");
        chk("t2_frame", frame_cnt, 2);
        chk("t2_proto", proto_err_cnt, 0);

        // Errored frame.
        clr();
        frame(3, 64'h3333_0000_0000_0000, 3'd5, 1'b1);
        run("t3_tmo", 3, 40);
        chk("t3_merr", {out_q[2].eop, out_q[2].err}, 2'b11);
        cmpq("t3_beat");
        chk("t3_err", err_cnt, 1);
        chk("t3_frame", frame_cnt, 3);

        // Framing violations: missing sop, double sop, unsolicited beat.
        clr();
        push(mk(64'h4444_0000_0000_00a0, 1'b0, 1'b1, 3'd2, 1'b0));
        run("t4a_tmo", 1, 30);
        chk("t4a_proto", proto_err_cnt, 1);
        push(mk(64'h4444_0000_0000_00b0, 1'b1, 1'b0, 3'd0, 1'b0));
        push(mk(64'h4444_0000_0000_00b1, 1'b1, 1'b0, 3'd0, 1'b0));
        push(mk(64'h4444_0000_0000_00b2, 1'b0, 1'b1, 3'd0, 1'b0));
        run("t4b_tmo", 4, 30);
        chk("t4b_proto", proto_err_cnt, 2);
        inj = mk(64'h4444_0000_0000_00c0, 1'b1, 1'b1, 3'd1, 1'b0);
        exp_q.push_back(inj);
        inj_pend = 1'b1;
        run("t4c_tmo", 5, 30);
        chk("t4c_proto", proto_err_cnt, 3);
        cmpq("t4_beat");
        chk("t4_frame", frame_cnt, 6);

        // Three back-to-back frames with avail held high.
        clr();
        frame(3, 64'h5555_0000_0000_0a00, 3'd1, 1'b0);
        frame(3, 64'h5555_0000_0000_0b00, 3'd2, 1'b0);
        frame(3, 64'h5555_0000_0000_0c00, 3'd4, 1'b0);
        run("t5_tmo", 9, 80);
        chk("t5_ren_cnt", ren_cnt, 9);
        chk("t5_eop_ren", eop_ren, 0);
        cmpq("t5_beat");
        chk("t5_frame", frame_cnt, 9);

        // Reset in the middle of a frame, then a clean frame.
        clr();
        frame(10, 64'h6666_0000_0000_0000, 3'd0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (pkt_rx_val && pkt_rx_data == 64'h6666_0000_0000_0005)
                found = 1'b1;
            else
                step();
        end
        chk("t6_reach", found, 1);
        chk("t6_pre_mvalid", m_valid, 1);
        rst = 1'b0;
        #1;
        chk("t6_ren", pkt_rx_ren, 0);
        chk("t6_mvalid", m_valid, 0);
        chk("t6_frame", frame_cnt, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_proto", proto_err_cnt, 0);
        mac_q.delete();
        drive('0);
        pkt_rx_val = 1'b0;
        pkt_rx_avail = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        step();
        clr();
        frame(2, 64'h7777_0000_0000_0000, 3'd6, 1'b0);
        run("t6b_tmo", 2, 30);
        cmpq("t6b_beat");
        chk("t6b_frame", frame_cnt, 1);
        chk("t6b_proto", proto_err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
